// File: rtl/rx_uart_bg.sv
// rx_uart_bg: 16x-oversampling UART receiver with an integrated baud tick generator.
// Recovers start / NB_DATA data bits (LSB first) / stop frames from i_rx and
// presents each byte with a one-cycle done pulse plus a frame-error flag.
module rx_uart_bg #(
    parameter int unsigned NB_DATA   = 8,
    parameter int unsigned SB_TICK   = 16,
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 19200
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_error
);

    localparam int unsigned M      = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned BR_W   = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned TICK_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer; resets to the idle (high) line level.
    logic sync1_q, sync2_q;
    logic rx_s;

    // Baud tick generator.
    logic [BR_W-1:0] br_q, br_d;
    logic            s_tick;

    // Receiver FSM state and datapath.
    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [NB_DATA-1:0]  shreg_q, shreg_d;
    logic [NB_DATA-1:0]  data_q, data_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    assign rx_s = sync2_q;

    // Bring the asynchronous serial line into the clock domain.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    // Free-running mod-M counter; s_tick marks its terminal count.
    always_comb begin
        s_tick = (br_q == BR_W'(M - 1));
        br_d   = s_tick ? '0 : br_q + BR_W'(1);
    end

    // Baud counter register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            br_q <= '0;
        end else begin
            br_q <= br_d;
        end
    end

    // Next-state and datapath logic; only start detection ignores s_tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_W'(NB_DATA - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        data_d  = shreg_q;
                        ferr_d  = ~rx_s;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_error  = ferr_q;

endmodule
